// File: rtl/byte_row_packer_pkg.sv
// Shared lane constants, state encoding and row type for the byte row packer
// and the widening stage that consumes its rows.
package byte_row_packer_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = $clog2(LANES);

  typedef logic [DATA_W-1:0] row_t [LANES];

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/row_fill_buffer.sv
// Fill buffer for one row: lane write decode, lane counter and zero-clear.
// row_c is the current buffer with this cycle's accepted byte bypassed in.
module row_fill_buffer
  import byte_row_packer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              emit_i,
  input  logic              keep_i,
  input  logic              clr_i,
  output logic [CNT_W-1:0]  cnt_o,
  output row_t              lanes_o,
  output row_t              row_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  row_t             lanes_q, lanes_d;

  always_comb begin
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    for (int i = 0; i < LANES; i++) begin
      row_c[i] = (acc_i && (cnt_q == CNT_W'(i))) ? data_i : lanes_q[i];
    end

    if (emit_i)     cnt_d = '0;
    else if (acc_i) cnt_d = cnt_q + CNT_W'(1);

    // A row leaving the buffer zeroes it; a parked row stays until released.
    if ((emit_i && !keep_i) || clr_i) lanes_d = '{default: '0};
    else if (acc_i || keep_i)         lanes_d = row_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      lanes_q <= '{default: '0};
    end else begin
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign lanes_o = lanes_q;

endmodule

// File: rtl/byte_row_packer.sv
// Packs a byte stream into 8-lane rows on a registered output; a second row
// may park in the fill buffer (HOLD) while the output is occupied.
module byte_row_packer
  import byte_row_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] Q0,
  output logic [DATA_W-1:0] Q1,
  output logic [DATA_W-1:0] Q2,
  output logic [DATA_W-1:0] Q3,
  output logic [DATA_W-1:0] Q4,
  output logic [DATA_W-1:0] Q5,
  output logic [DATA_W-1:0] Q6,
  output logic [DATA_W-1:0] Q7,
  output logic              out_valid,
  input  logic              out_ready
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  row_t             q_q, q_d;
  logic             accept, emit, out_free, last_lane, keep, clr;
  logic [CNT_W-1:0] cnt;
  row_t             lanes;
  row_t             row_c;

  row_fill_buffer u_fill (
    .clk     (clk),
    .rst_n   (reset),
    .acc_i   (accept),
    .data_i  (in_data),
    .emit_i  (emit),
    .keep_i  (keep),
    .clr_i   (clr),
    .cnt_o   (cnt),
    .lanes_o (lanes),
    .row_c   (row_c)
  );

  always_comb begin
    accept    = in_valid && (state_q == ST_FILL);
    last_lane = (cnt == CNT_W'(LANES - 1));
    emit      = (state_q == ST_FILL) &&
                ((accept && last_lane) || (flush && ((cnt != '0) || accept)));
    out_free  = !out_valid_q || out_ready;

    state_d     = state_q;
    out_valid_d = out_valid_q;
    q_d         = q_q;
    keep        = 1'b0;
    clr         = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if ((state_q == ST_HOLD) && out_ready) begin
      // Parked row moves to the output as the current one is taken.
      q_d         = lanes;
      out_valid_d = 1'b1;
      clr         = 1'b1;
      state_d     = ST_FILL;
    end else if (emit) begin
      if (out_free) begin
        q_d         = row_c;
        out_valid_d = 1'b1;
      end else begin
        keep    = 1'b1;
        state_d = ST_HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_FILL;
      out_valid_q <= 1'b0;
      q_q         <= '{default: '0};
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
    end
  end

  assign in_ready  = (state_q == ST_FILL);
  assign out_valid = out_valid_q;
  assign Q0 = q_q[0];
  assign Q1 = q_q[1];
  assign Q2 = q_q[2];
  assign Q3 = q_q[3];
  assign Q4 = q_q[4];
  assign Q5 = q_q[5];
  assign Q6 = q_q[6];
  assign Q7 = q_q[7];

endmodule

// File: tb/tb_byte_row_packer.sv
// Scoreboard bench for byte_row_packer: a queue-based model predicts rows and
// handshake levels, a negedge monitor checks every row the DUT hands over.
module tb_byte_row_packer;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
  logic       out_valid;
  logic       out_ready;

  int total = 0;
  int bad   = 0;

  logic [7:0]  part[$];   // bytes of the row being collected
  logic [63:0] exp_q[$];  // rows formed, oldest first, not yet handed over
  int          n_rows = 0; // rows inside the DUT (output slot + parked row)

  byte_row_packer dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .Q0        (Q0),
    .Q1        (Q1),
    .Q2        (Q2),
    .Q3        (Q3),
    .Q4        (Q4),
    .Q5        (Q5),
    .Q6        (Q6),
    .Q7        (Q7),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] q_bus();
    return {Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each handover (out_valid && out_ready at the next edge) pops a row.
  always @(negedge clk) begin
    if (reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL row_unexpected: got %h expected no row at %0t", q_bus(), $time);
      end else begin
        chk("row", q_bus(), exp_q.pop_front());
      end
    end
  end

  // One cycle: drive, check handshake levels at negedge, advance the model.
  task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
    logic        acc;
    logic        form;
    logic [63:0] row;
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(n_rows < 2));
    chk("out_valid", 64'(out_valid), 64'(n_rows > 0));
    acc = v && (n_rows < 2);
    if (acc) part.push_back(d);
    form = (acc && part.size() == 8) || (f && n_rows < 2 && part.size() > 0);
    if (n_rows > 0 && r) n_rows--;
    if (form) begin
      row = '0;
      foreach (part[i]) row[i*8 +: 8] = part[i];
      exp_q.push_back(row);
      part.delete();
      n_rows++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, r);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    chk("rst_q", q_bus(), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    part.delete();
    exp_q.delete();
    n_rows = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1;
    do_reset();

    // single row
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    idle(2, 1'b1);

    // back-to-back rows
    for (int i = 16; i < 32; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    idle(2, 1'b1);

    // backpressure into HOLD, 17th byte refused, single-cycle release
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // partial-row flush, then a row starting in lane 0
    step(1'b1, 8'hA1, 1'b0, 1'b1);
    step(1'b1, 8'hA2, 1'b0, 1'b1);
    step(1'b1, 8'hA3, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b1);
    idle(2, 1'b1);

    // idle flush, flush together with the 8th byte, flush with a byte at lane 0
    step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b1);
    step(1'b1, 8'hC7, 1'b1, 1'b1);
    step(1'b1, 8'hD0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // reset mid-row discards buffered bytes
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b1);
    idle(2, 1'b1);

    // reset while a row is parked
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b1);
    idle(2, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 2) != 0));
    end

    step(1'b0, 8'h00, 1'b1, 1'b1);
    idle(4, 1'b1);
    chk("drained", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
